dsp_mac_sequencer: RTL and testbench
====================================

Name: dsp_mac_sequencer

Overview:
- Upstream controller for the DSP48A1 slice. It accepts (A,B) operand pairs over a valid/ready handshake and drives the slice's A, B and OPMODE pins with correct pipeline alignment.
- The slice accumulates N_TERMS products into P. The block tracks in-flight terms with a tag pipeline, then captures the final P and carry-out flag into a one-deep result register with its own valid/ready handshake.
- It sits between a sample/coefficient source and the DSP slice, so dot products and FIR taps run with no software OPMODE management.

Parameters:
- N_TERMS, 4, products accumulated per result; minimum 1.
- OP_DELAY, 2, clock edges from the accepting edge of a term to the edge that presents that term's OPMODE on DSP_OPMODE. Default matches a slice with A0/A1/B0/B1/OPMODE registers enabled.
- P_LAT, 4, edges from the accepting edge of a term to the edge at which DSP_P/DSP_CARRYOUT reflect that term.

Ports:
- CLK  in  1  clock; all state is updated on the rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  operand pair valid.
- IN_READY  out  1  block can accept a pair.
- IN_A  in  18  multiplicand, unsigned.
- IN_B  in  18  multiplier, unsigned.
- DSP_A  out  18  to slice A.
- DSP_B  out  18  to slice B (B_INPUT="DIRECT", OPMODE[4]=0 path).
- DSP_OPMODE  out  8  to slice OPMODE.
- DSP_CE  out  1  common clock enable for the slice's CEA/CEB/CEM/CEP/CEOPMODE/CECARRYIN.
- DSP_P  in  48  slice P.
- DSP_CARRYOUT  in  1  slice CARRYOUT.
- RES_VALID  out  1  result available.
- RES_READY  in  1  consumer accepts result.
- RES_DATA  out  48  accumulated sum, low 48 bits.
- RES_OVF  out  1  at least one carry-out occurred during this accumulation.

Behaviour:
- Accept: a term is accepted on an edge where IN_VALID and IN_READY are both high.
  - On that edge DSP_A<=IN_A and DSP_B<=IN_B. When no term is accepted, DSP_A and DSP_B hold their values.
- OPMODE codes: first term of a vector = 8'h01 (X=multiplier, Z=0). Later terms = 8'h09 (X=multiplier, Z=P). Bubble or idle = 8'h08 (X=0, Z=P; P held). Pre-adder, carry-in and subtract bits are always 0.
- OPMODE alignment: the code for a term is shifted through an OP_DELAY-deep register chain. A non-accepting cycle inserts 8'h08. The chain output drives DSP_OPMODE, so a term's code appears exactly OP_DELAY edges after its accepting edge.
- DSP_CE is 0 while RSTN is low and 1 otherwise. The slice pipeline free-runs; bubbles are neutralised by code 8'h08.
- Term counter: width max(1,$clog2(N_TERMS)), counting 0..N_TERMS-1. It increments per accepted term and wraps to 0 on the last term.
- Tag pipeline: a P_LAT-deep shift register carrying {valid,last} per cycle, with {0,0} inserted on bubbles.
  - On the edge after a valid tag exits, RES_OVF_acc |= DSP_CARRYOUT.
  - On the edge after a last tag exits, RES_DATA<=DSP_P, RES_OVF<=(RES_OVF_acc|DSP_CARRYOUT), RES_VALID<=1, and RES_OVF_acc is cleared.
- Latency: RES_VALID rises P_LAT+1 edges after the accepting edge of the last term. With back-to-back input, a 4-term vector yields its result 8 edges after the first accept.
- State machine:
  - IDLE (IN_READY=1): accepting term 0 goes to ACCUM, or to DRAIN if N_TERMS=1.
  - ACCUM (IN_READY=1): accepting the last term goes to DRAIN.
  - DRAIN (IN_READY=0): the last tag exiting goes to DONE.
  - DONE (IN_READY=0, RES_VALID=1): RES_VALID&RES_READY goes to IDLE and clears RES_VALID.
  - IN_READY is decoded from the registered state only. A new vector can be accepted no earlier than the cycle after the result handshake.
- Bubbles: IN_VALID low in ACCUM stalls nothing. The slice keeps P via code 8'h08 and the sum is unaffected.
- Arithmetic: unsigned products accumulate modulo 2^48. Overflow is signalled only through RES_OVF and is never saturated.
- Result hold: RES_DATA and RES_OVF hold stable while RES_VALID=1 and RES_READY=0.
- Reset (asynchronous, any time including mid-vector), all values forced immediately:
  - state=IDLE, counter=0, all tags={0,0}, OPMODE chain=8'h00.
  - DSP_OPMODE=8'h00, DSP_A=0, DSP_B=0, DSP_CE=0.
  - RES_VALID=0, RES_DATA=0, RES_OVF=0, RES_OVF_acc=0, IN_READY=0 while RSTN low.
  - Partial sums are discarded. The first vector after reset starts with 8'h01, so no stale P leaks.

Test Plan:
- Basic dot product: N_TERMS=4, back-to-back pairs (1,2),(3,4),(5,6),(7,8), RES_READY=1 -> RES_DATA=100, RES_OVF=0, RES_VALID rises 8 edges after the first accept, IN_READY low from the 4th accept until the edge after the handshake.
- Bubbles: same pairs with IN_VALID low for 3 cycles between terms 2 and 3 -> RES_DATA=100; DSP_OPMODE shows 8'h08 during the gaps (delayed OP_DELAY edges).
- Backpressure: RES_READY=0 for 10 cycles after RES_VALID -> RES_DATA stable at 100, IN_READY=0 throughout; a second vector of (2,2)x4 then gives 16, with no carry-over from the first.
- N_TERMS=1: pairs (18'h3FFFF,18'h3FFFF) then (10,10) -> results 36'hFFFF80001 and 100; every DSP_OPMODE issue is 8'h01.
- Overflow: N_TERMS=4097, all pairs 18'h3FFFF -> RES_OVF=1 and RES_DATA = 4097*(2^36-2^19+1) mod 2^48.
- Reset mid-vector: RSTN low for 2 cycles after term 2 of 4, then a full (1,1)x4 vector -> RES_DATA=4, no spurious RES_VALID during or after reset, outputs at reset values while RSTN low.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// Upstream controller for a DSP48A1 slice: issues A/B/OPMODE for N_TERMS-long
// multiply-accumulate vectors and captures the final P into a result register.
module dsp_mac_sequencer #(
  parameter int N_TERMS  = 4,
  parameter int OP_DELAY = 2,
  parameter int P_LAT    = 4
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [17:0] IN_A,
  input  logic [17:0] IN_B,
  output logic [17:0] DSP_A,
  output logic [17:0] DSP_B,
  output logic [7:0]  DSP_OPMODE,
  output logic        DSP_CE,
  input  logic [47:0] DSP_P,
  input  logic        DSP_CARRYOUT,
  output logic        RES_VALID,
  input  logic        RES_READY,
  output logic [47:0] RES_DATA,
  output logic        RES_OVF
);
  localparam int CW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N_TERMS - 1);
  localparam logic [7:0] OP_FIRST = 8'h01;
  localparam logic [7:0] OP_NEXT  = 8'h09;
  localparam logic [7:0] OP_HOLD  = 8'h08;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] term_cnt;
  logic [7:0]    op_code;
  logic          accept, is_last, tag_valid, tag_last, ovf_acc;

  // Stage 0 of each pipe is loaded on the accepting edge, so the last stage
  // lines up with the slice: OPMODE after OP_DELAY edges, P after P_LAT edges.
  logic [7:0] op_pipe  [OP_DELAY+1];
  logic [1:0] tag_pipe [P_LAT+1];

  assign accept     = IN_VALID && IN_READY;
  assign is_last    = (term_cnt == LAST_IDX);
  assign tag_valid  = tag_pipe[P_LAT][1];
  assign tag_last   = tag_pipe[P_LAT][0];
  assign DSP_OPMODE = op_pipe[OP_DELAY];
  assign DSP_CE     = RSTN;
  assign IN_READY   = RSTN && ((state == IDLE) || (state == ACCUM));
  assign RES_VALID  = (state == DONE);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    op_code   = OP_HOLD;
    if (accept) op_code = (term_cnt == '0) ? OP_FIRST : OP_NEXT;
    case (state)
      IDLE:    if (accept) state_nxt = is_last ? DRAIN : ACCUM;
      ACCUM:   if (accept && is_last) state_nxt = DRAIN;
      DRAIN:   if (tag_valid && tag_last) state_nxt = DONE;
      DONE:    if (RES_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      term_cnt <= '0;
      DSP_A    <= '0;
      DSP_B    <= '0;
      for (int i = 0; i <= OP_DELAY; i++) op_pipe[i] <= 8'h00;
      for (int i = 0; i <= P_LAT; i++) tag_pipe[i] <= 2'b00;
    end else begin
      if (accept) begin
        DSP_A    <= IN_A;
        DSP_B    <= IN_B;
        term_cnt <= is_last ? '0 : term_cnt + CW'(1);
      end
      op_pipe[0]  <= op_code;
      tag_pipe[0] <= {accept, accept && is_last};
      for (int i = 1; i <= OP_DELAY; i++) op_pipe[i] <= op_pipe[i-1];
      for (int i = 1; i <= P_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  // Carry-outs of every term are folded into the flag reported with the result.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      RES_DATA <= '0;
      RES_OVF  <= 1'b0;
      ovf_acc  <= 1'b0;
    end else if (tag_valid) begin
      if (tag_last) begin
        RES_DATA <= DSP_P;
        RES_OVF  <= ovf_acc | DSP_CARRYOUT;
        ovf_acc  <= 1'b0;
      end else begin
        ovf_acc <= ovf_acc | DSP_CARRYOUT;
      end
    end
  end
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: 4-, 1- and 4097-term instances, each driving a
// behavioural DSP48A1 model, checked against a transaction-level reference.
`timescale 1ns/1ps
module tb_dsp_mac_sequencer;
  localparam int NI       = 3;
  localparam int OP_DELAY = 2;
  localparam int P_LAT    = 4;

  typedef struct packed {
    logic [47:0] data;
    logic        ovf;
    logic [31:0] due;
  } res_t;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  logic        in_valid   [NI];
  logic        in_ready   [NI];
  logic [17:0] in_a       [NI];
  logic [17:0] in_b       [NI];
  logic [17:0] dsp_a      [NI];
  logic [17:0] dsp_b      [NI];
  logic [7:0]  dsp_opmode [NI];
  logic        dsp_ce     [NI];
  logic [47:0] dsp_p      [NI];
  logic        dsp_co     [NI];
  logic        res_valid  [NI];
  logic        res_ready  [NI];
  logic [47:0] res_data   [NI];
  logic        res_ovf    [NI];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int act = 0;
  int readyMode = 0;

  logic [7:0]  issued [64];
  logic [17:0] lastA [NI];
  logic [17:0] lastB [NI];
  int          refCnt = 0;
  logic [47:0] refSum = '0;
  logic        refOvf = 1'b0;
  logic        busyRef = 1'b0;
  res_t        expQ [$];
  logic [47:0] lastData = '0;
  logic        lastOvf = 1'b0;
  int          firstAcc = 0;
  int          riseCyc = 0;
  logic        prevValid = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ntOf(input int g);
    return (g == 0) ? 4 : (g == 1) ? 1 : 4097;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gen_inst
    localparam int NTG = (g == 0) ? 4 : (g == 1) ? 1 : 4097;
    logic [17:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic [35:0] m = '0;
    logic [7:0]  opr = '0;
    logic [47:0] p = '0;
    logic        co = 1'b0;

    dsp_mac_sequencer #(.N_TERMS(NTG), .OP_DELAY(OP_DELAY), .P_LAT(P_LAT)) dut (
      .CLK(clk), .RSTN(rstn),
      .IN_VALID(in_valid[g]), .IN_READY(in_ready[g]),
      .IN_A(in_a[g]), .IN_B(in_b[g]),
      .DSP_A(dsp_a[g]), .DSP_B(dsp_b[g]),
      .DSP_OPMODE(dsp_opmode[g]), .DSP_CE(dsp_ce[g]),
      .DSP_P(dsp_p[g]), .DSP_CARRYOUT(dsp_co[g]),
      .RES_VALID(res_valid[g]), .RES_READY(res_ready[g]),
      .RES_DATA(res_data[g]), .RES_OVF(res_ovf[g])
    );

    // Slice with A0/A1, B0/B1, M, OPMODE and P registers; X=M or 0, Z=P or 0.
    always @(posedge clk) begin
      if (dsp_ce[g]) begin
        a0  <= dsp_a[g];
        a1  <= a0;
        b0  <= dsp_b[g];
        b1  <= b0;
        m   <= 36'(a1) * 36'(b1);
        opr <= dsp_opmode[g];
        {co, p} <= ((opr[3:2] == 2'b10) ? {1'b0, p} : 49'd0)
                 + ((opr[1:0] == 2'b01) ? {13'd0, m} : 49'd0);
      end
    end
    assign dsp_p[g]  = p;
    assign dsp_co[g] = co;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Reference: each term is a handshake; a vector's sum is plain modular
  // arithmetic, its result due P_LAT+1 edges after the last accept.
  task automatic modelStep();
    int g;
    logic expValid;
    logic [35:0] prod;
    logic [48:0] s;
    g = act;
    if (!rstn) begin
      expQ.delete();
      busyRef = 1'b0;
      refCnt = 0;
      refSum = '0;
      refOvf = 1'b0;
      for (int i = 0; i < NI; i++) begin
        lastA[i] = '0;
        lastB[i] = '0;
      end
      for (int k = -2; k <= 1; k++) issued[(cyc + k) & 63] = 8'h00;
    end
    checkOutput("opmode", dsp_opmode[g], issued[(cyc - 2) & 63]);
    checkOutput("ce", dsp_ce[g], rstn);
    checkOutput("inReady", in_ready[g], rstn && !busyRef);
    checkOutput("dspA", dsp_a[g], lastA[g]);
    checkOutput("dspB", dsp_b[g], lastB[g]);
    for (int i = 0; i < NI; i++)
      if (i != g) checkOutput("idleValid", res_valid[i], 1'b0);
    expValid = (expQ.size() > 0) && (cyc >= int'(expQ[0].due));
    checkOutput("resValid", res_valid[g], expValid);
    if (expValid) begin
      checkOutput("resData", res_data[g], expQ[0].data);
      checkOutput("resOvf", res_ovf[g], expQ[0].ovf);
    end else if (!rstn) begin
      checkOutput("rstData", res_data[g], 48'd0);
      checkOutput("rstOvf", res_ovf[g], 1'b0);
    end
    if (res_valid[g] && !prevValid) riseCyc = cyc;
    prevValid = res_valid[g];
    if (res_valid[g] && res_ready[g]) begin
      lastData = res_data[g];
      lastOvf  = res_ovf[g];
      if (expQ.size() > 0) void'(expQ.pop_front());
      busyRef = 1'b0;
    end
    if (rstn && in_valid[g] && in_ready[g]) begin
      if (refCnt == 0) firstAcc = cyc + 1;
      issued[(cyc + 1) & 63] = (refCnt == 0) ? 8'h01 : 8'h09;
      prod = 36'(in_a[g]) * 36'(in_b[g]);
      s = {1'b0, refSum} + {13'd0, prod};
      if (s[48]) refOvf = 1'b1;
      refSum = s[47:0];
      lastA[g] = in_a[g];
      lastB[g] = in_b[g];
      refCnt++;
      if (refCnt == ntOf(g)) begin
        expQ.push_back('{data: refSum, ovf: refOvf, due: 32'(cyc + 1 + P_LAT + 1)});
        refCnt = 0;
        refSum = '0;
        refOvf = 1'b0;
        busyRef = 1'b1;
      end
    end else begin
      issued[(cyc + 1) & 63] = rstn ? 8'h08 : 8'h00;
    end
  endtask

  always @(negedge clk) modelStep();

  initial begin
    for (int i = 0; i < NI; i++) res_ready[i] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++)
        res_ready[i] = (readyMode == 0) ? 1'b1 :
                       (readyMode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic applyStimulus(input int g, input logic [17:0] a, input logic [17:0] b);
    logic took;
    int n;
    took = 1'b0;
    n = 0;
    in_a[g] = a;
    in_b[g] = b;
    in_valid[g] = 1'b1;
    while (!took && n < 300) begin
      @(negedge clk);
      took = in_ready[g];
      @(posedge clk);
      #1;
      n++;
    end
    in_valid[g] = 1'b0;
    if (!took) checkOutput("acceptTimeout", 64'd0, 64'd1);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitResult();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("resultDrained", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] bigExp;
    int n;
    for (int i = 0; i < NI; i++) begin
      in_valid[i] = 1'b0;
      in_a[i] = '0;
      in_b[i] = '0;
      lastA[i] = '0;
      lastB[i] = '0;
    end
    for (int i = 0; i < 64; i++) issued[i] = 8'h00;
    #1 rstn = 1'b0;
    idleCycles(3);
    rstn = 1'b1;
    idleCycles(2);

    // basic dot product on the 4-term instance
    applyStimulus(0, 18'd1, 18'd2);
    applyStimulus(0, 18'd3, 18'd4);
    applyStimulus(0, 18'd5, 18'd6);
    applyStimulus(0, 18'd7, 18'd8);
    waitResult();
    checkOutput("basicSum", lastData, 48'd100);
    checkOutput("basicOvf", lastOvf, 1'b0);
    checkOutput("basicLatency", 64'(riseCyc - firstAcc), 64'd8);

    // bubbles between terms 2 and 3
    applyStimulus(0, 18'd1, 18'd2);
    applyStimulus(0, 18'd3, 18'd4);
    idleCycles(3);
    applyStimulus(0, 18'd5, 18'd6);
    applyStimulus(0, 18'd7, 18'd8);
    waitResult();
    checkOutput("bubbleSum", lastData, 48'd100);

    // result backpressure, then a fresh vector
    readyMode = 2;
    applyStimulus(0, 18'd1, 18'd2);
    applyStimulus(0, 18'd3, 18'd4);
    applyStimulus(0, 18'd5, 18'd6);
    applyStimulus(0, 18'd7, 18'd8);
    n = 0;
    while (!res_valid[0] && n < 50) begin
      idleCycles(1);
      n++;
    end
    checkOutput("bpValidSeen", res_valid[0], 1'b1);
    idleCycles(10);
    checkOutput("bpHeldData", res_data[0], 48'd100);
    checkOutput("bpReadyLow", in_ready[0], 1'b0);
    readyMode = 0;
    waitResult();
    for (int t = 0; t < 4; t++) applyStimulus(0, 18'd2, 18'd2);
    waitResult();
    checkOutput("secondSum", lastData, 48'd16);

    // random operands, bubbles and result backpressure
    readyMode = 1;
    for (int v = 0; v < 15; v++) begin
      for (int t = 0; t < 4; t++) begin
        applyStimulus(0, 18'($urandom), 18'($urandom));
        if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 3));
      end
      if ($urandom_range(0, 1) == 1) waitResult();
    end
    waitResult();
    readyMode = 0;
    idleCycles(3);

    // reset in the middle of a vector
    applyStimulus(0, 18'd1, 18'd1);
    applyStimulus(0, 18'd1, 18'd1);
    rstn = 1'b0;
    idleCycles(2);
    rstn = 1'b1;
    idleCycles(1);
    for (int t = 0; t < 4; t++) applyStimulus(0, 18'd1, 18'd1);
    waitResult();
    checkOutput("afterResetSum", lastData, 48'd4);
    idleCycles(4);

    // single-term vectors
    act = 1;
    prevValid = 1'b0;
    idleCycles(1);
    applyStimulus(1, 18'h3FFFF, 18'h3FFFF);
    waitResult();
    checkOutput("oneTermMax", lastData, 48'hF_FFF8_0001);
    applyStimulus(1, 18'd10, 18'd10);
    waitResult();
    checkOutput("oneTermSmall", lastData, 48'd100);
    idleCycles(4);

    // long vector that wraps past 2^48, then one that must not inherit the flag
    act = 2;
    prevValid = 1'b0;
    idleCycles(1);
    for (int t = 0; t < 4097; t++) applyStimulus(2, 18'h3FFFF, 18'h3FFFF);
    waitResult();
    bigExp = (64'd4097 * ((64'd1 << 36) - (64'd1 << 19) + 64'd1)) & 64'hFFFF_FFFF_FFFF;
    checkOutput("ovfData", lastData, bigExp);
    checkOutput("ovfFlag", lastOvf, 1'b1);
    for (int t = 0; t < 4097; t++) applyStimulus(2, 18'd1, 18'd1);
    waitResult();
    checkOutput("noOvfData", lastData, 48'd4097);
    checkOutput("noOvfFlag", lastOvf, 1'b0);
    idleCycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
